traffic_source: RTL



---
 rtl/traffic_source_if.sv | 33 +++
 rtl/traffic_source.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_source_if.sv
// ============================================================================
// Module   : traffic_source_if
// Purpose  : Serial link and progress counters between a traffic source and
//            its consumer (router input port or testbench).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface traffic_source_if;
  logic        data;
  logic        busy;
  logic [15:0] packets_sent;
  logic [15:0] flits_sent;
  logic        done;

  modport master (
    output data,
    output packets_sent,
    output flits_sent,
    output done,
    input  busy
  );

  modport slave (
    input  data,
    input  packets_sent,
    input  flits_sent,
    input  done,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/traffic_source.sv
// ============================================================================
// Module   : traffic_source
// Purpose  : Multi-flit packet generator with programmable injection period,
//            fixed / LFSR-random / bit-complement destinations, start-bit
//            serial framing toward one router input port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traffic_source #(
  parameter int          ID            = 0,
  parameter int          NUM_NODES     = 16,
  parameter int          FLIT_WIDTH    = 8,
  parameter int          DEST_BITS     = 4,
  parameter int          PACKET_FLITS  = 3,
  parameter int          MAX_PACKETS   = 4,
  parameter int          INJECT_PERIOD = 40,
  parameter int          MODE          = 0,
  parameter int          FIXED_DEST    = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  traffic_source_if.master tx
);

  localparam int BW = $clog2(FLIT_WIDTH + 2);
  localparam int IW = $clog2(PACKET_FLITS + 1);
  localparam logic [BW-1:0]        LAST_BIT  = BW'(FLIT_WIDTH + 1);
  localparam logic [IW-1:0]        LAST_FLIT = IW'(PACKET_FLITS - 1);
  localparam logic [15:0]          LFSR_INIT = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [15:0]          MAXP      = 16'(MAX_PACKETS);
  localparam logic [DEST_BITS-1:0] ID_F      = DEST_BITS'(ID);
  localparam logic [DEST_BITS-1:0] ID_INV    = ~ID_F;
  localparam logic [DEST_BITS-1:0] FIXED_F   = DEST_BITS'(FIXED_DEST);
  localparam logic [DEST_BITS-1:0] COMP_F    = DEST_BITS'(32'(ID_INV) % 32'(NUM_NODES));

  typedef enum logic [1:0] {
    ST_GAP    = 2'd0,
    ST_CHOOSE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [15:0]           gap_q,      gap_d;
  logic [IW-1:0]         flit_idx_q, flit_idx_d;
  logic [BW-1:0]         bit_idx_q,  bit_idx_d;
  logic [FLIT_WIDTH:0]   frame_q,    frame_d;
  logic                  data_q,     data_d;
  logic [15:0]           pkts_q,     pkts_d;
  logic [15:0]           flits_q,    flits_d;
  logic                  done_q,     done_d;
  logic [15:0]           lfsr_q,     lfsr_d;
  logic [DEST_BITS-1:0]  dest_q,     dest_d;
  logic                  first_q,    first_d;

  logic [15:0]           w_lfsr_next;
  logic [31:0]           w_rand;
  logic [DEST_BITS-1:0]  w_new_dest;
  logic [FLIT_WIDTH-1:0] w_head;
  logic [FLIT_WIDTH-1:0] w_body;
  logic [FLIT_WIDTH-1:0] w_payload;
  logic                  w_tail;
  logic [15:0]           w_pkts_inc;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign w_lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    w_rand     = 32'(lfsr_q[DEST_BITS-1:0]) % 32'(NUM_NODES);
    if (w_rand == 32'(ID)) begin
      w_rand = (32'(ID) + 32'd1) % 32'(NUM_NODES);
    end
    case (MODE)
      1:       w_new_dest = w_rand[DEST_BITS-1:0];
      2:       w_new_dest = COMP_F;
      default: w_new_dest = FIXED_F;
    endcase
  end

  always_comb begin
    w_head                          = '0;
    w_head[DEST_BITS-1:0]           = dest_q;
    w_head[2*DEST_BITS-1:DEST_BITS] = ID_F;
    w_body    = FLIT_WIDTH'({pkts_q, DEST_BITS'(flit_idx_q)});
    w_payload = (flit_idx_q == '0) ? w_head : w_body;
    w_tail    = (flit_idx_q == LAST_FLIT);
    w_pkts_inc = (pkts_q == 16'hFFFF) ? pkts_q : pkts_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    flit_idx_d = flit_idx_q;
    bit_idx_d  = bit_idx_q;
    frame_d    = frame_q;
    data_d     = 1'b0;
    pkts_d     = pkts_q;
    flits_d    = flits_q;
    done_d     = done_q;
    lfsr_d     = lfsr_q;
    dest_d     = dest_q;
    first_d    = first_q;

    case (state_q)
      ST_GAP: begin
        if (!done_q && (first_q || ({16'd0, gap_q} + 32'd1 >= 32'(INJECT_PERIOD)))) begin
          state_d = ST_CHOOSE;
        end
      end
      ST_CHOOSE: begin
        dest_d     = w_new_dest;
        lfsr_d     = w_lfsr_next;
        flit_idx_d = '0;
        first_d    = 1'b0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx.busy) begin
          data_d    = 1'b1;
          frame_d   = {w_tail, w_payload};
          bit_idx_d = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // One idle cycle after the tail bit gives the FLIT_WIDTH+3 flit pitch.
        if (bit_idx_q == LAST_BIT) begin
          flits_d = (flits_q == 16'hFFFF) ? flits_q : flits_q + 16'd1;
          if (w_tail) begin
            pkts_d  = w_pkts_inc;
            done_d  = done_q | ((MAX_PACKETS != 0) && (w_pkts_inc >= MAXP));
            state_d = ST_GAP;
          end else begin
            flit_idx_d = flit_idx_q + IW'(1);
            state_d    = ST_WAIT;
          end
        end else begin
          data_d    = frame_q[0];
          frame_d   = frame_q >> 1;
          bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      default: state_d = ST_GAP;
    endcase

    // Gap counter measures cycles since the most recent CHOOSE.
    if (state_d == ST_CHOOSE) begin
      gap_d = '0;
    end else begin
      gap_d = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GAP;
      gap_q      <= '0;
      flit_idx_q <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      data_q     <= 1'b0;
      pkts_q     <= '0;
      flits_q    <= '0;
      done_q     <= 1'b0;
      lfsr_q     <= LFSR_INIT;
      dest_q     <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      flit_idx_q <= flit_idx_d;
      bit_idx_q  <= bit_idx_d;
      frame_q    <= frame_d;
      data_q     <= data_d;
      pkts_q     <= pkts_d;
      flits_q    <= flits_d;
      done_q     <= done_d;
      lfsr_q     <= lfsr_d;
      dest_q     <= dest_d;
      first_q    <= first_d;
    end
  end

  assign tx.data         = data_q;
  assign tx.packets_sent = pkts_q;
  assign tx.flits_sent   = flits_q;
  assign tx.done         = done_q;

endmodule

`default_nettype wire
